// File: rtl/vga_pkg.sv
// Shared constants and types for the text-buffer write arbiter.
// Optional feature macro: VGA_ARB_VBLANK_EN (restricts buffer writes to vertical blanking).
package vga_pkg;

    localparam int BUF_ADDR_WIDTH = 10;
    localparam int N_WORDS        = 600;
    localparam int CHAR_WIDTH     = 7;
    localparam int CHARS_PER_WORD = 4;
    localparam int DATA_WIDTH     = CHAR_WIDTH * CHARS_PER_WORD;

    localparam int REQ_HOST = 0;
    localparam int REQ_TERM = 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        FILL = 2'd1,
        DONE = 2'd2
    } fill_state_e;

endpackage

// File: rtl/vga_rr_arb2.sv
// Two-way round-robin arbiter: a lone requester wins at once, a tie goes to the
// requester that did not win last. The pointer moves only when a grant is issued.
module vga_rr_arb2
    import vga_pkg::*;
(
    input  logic       clk_i,
    input  logic       rstn_i,
    input  logic [1:0] req,
    input  logic       en,
    output logic [1:0] gnt
);

    // High when the terminal engine was the most recent winner.
    logic last_term;

    always_comb begin
        gnt = '0;
        if (en) begin
            gnt[REQ_HOST] = req[REQ_HOST] & (~req[REQ_TERM] | last_term);
            gnt[REQ_TERM] = req[REQ_TERM] & (~req[REQ_HOST] | ~last_term);
        end
    end

    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            last_term <= 1'b1;
        end else if (gnt[REQ_HOST]) begin
            last_term <= 1'b0;
        end else if (gnt[REQ_TERM]) begin
            last_term <= 1'b1;
        end
    end

endmodule

// File: rtl/vga_buf_wr_arbiter.sv
// Sole owner of the text-buffer write port: arbitrates host/terminal writes and runs a full-screen fill.
// Optional feature macro: VGA_ARB_VBLANK_EN (grants and fill steps only while vblank_i is high).
module vga_buf_wr_arbiter
    import vga_pkg::*;
(
    input  logic                      clk_i,
    input  logic                      rstn_i,
    input  logic                      host_req_i,
    input  logic [BUF_ADDR_WIDTH-1:0] host_addr_i,
    input  logic [DATA_WIDTH-1:0]     host_data_i,
    input  logic [CHARS_PER_WORD-1:0] host_strb_i,
    output logic                      host_gnt_o,
    input  logic                      term_req_i,
    input  logic [BUF_ADDR_WIDTH-1:0] term_addr_i,
    input  logic [DATA_WIDTH-1:0]     term_data_i,
    input  logic [CHARS_PER_WORD-1:0] term_strb_i,
    output logic                      term_gnt_o,
    input  logic                      fill_start_i,
    input  logic [CHAR_WIDTH-1:0]     fill_char_i,
    input  logic                      vblank_i,
    output logic                      busy_o,
    output logic                      fill_done_o,
    output logic                      addr_err_o,
    output logic                      wr_en_o,
    output logic [BUF_ADDR_WIDTH-1:0] w_addr_o,
    output logic [DATA_WIDTH-1:0]     w_data_o,
    output logic [CHARS_PER_WORD-1:0] w_strb_o
);

    localparam logic [BUF_ADDR_WIDTH-1:0] LAST_ADDR  = BUF_ADDR_WIDTH'(N_WORDS - 1);
    localparam logic [BUF_ADDR_WIDTH-1:0] ADDR_LIMIT = BUF_ADDR_WIDTH'(N_WORDS);

    fill_state_e               state;
    logic [BUF_ADDR_WIDTH-1:0] fill_cnt;
    logic [CHAR_WIDTH-1:0]     fill_char;

    logic                      slot_ok;
    logic                      arb_en;
    logic [1:0]                req;
    logic [1:0]                gnt;
    logic                      sel_valid;
    logic [BUF_ADDR_WIDTH-1:0] sel_addr;
    logic [DATA_WIDTH-1:0]     sel_data;
    logic [CHARS_PER_WORD-1:0] sel_strb;

`ifdef VGA_ARB_VBLANK_EN
    assign slot_ok = vblank_i;
`else
    logic unused_vblank;
    assign unused_vblank = vblank_i;
    assign slot_ok       = 1'b1;
`endif

    // A fill start in IDLE takes the write slot of that cycle, so requesters are held off.
    assign arb_en = slot_ok && (state != FILL) && !((state == IDLE) && fill_start_i);

    assign req[REQ_HOST] = host_req_i;
    assign req[REQ_TERM] = term_req_i;

    vga_rr_arb2 u_rr_arb (
        .clk_i  (clk_i),
        .rstn_i (rstn_i),
        .req    (req),
        .en     (arb_en),
        .gnt    (gnt)
    );

    assign host_gnt_o = gnt[REQ_HOST];
    assign term_gnt_o = gnt[REQ_TERM];

    always_comb begin
        sel_valid = |gnt;
        sel_addr  = host_addr_i;
        sel_data  = host_data_i;
        sel_strb  = host_strb_i;
        if (gnt[REQ_TERM]) begin
            sel_addr = term_addr_i;
            sel_data = term_data_i;
            sel_strb = term_strb_i;
        end
    end

    // Fill FSM and the registered write port; grants and fill writes never share a cycle.
    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            state       <= IDLE;
            fill_cnt    <= '0;
            fill_char   <= '0;
            busy_o      <= 1'b0;
            fill_done_o <= 1'b0;
            addr_err_o  <= 1'b0;
            wr_en_o     <= 1'b0;
            w_addr_o    <= '0;
            w_data_o    <= '0;
            w_strb_o    <= '0;
        end else begin
            wr_en_o     <= 1'b0;
            addr_err_o  <= 1'b0;
            fill_done_o <= 1'b0;

            case (state)
                IDLE: begin
                    if (fill_start_i) begin
                        state     <= FILL;
                        fill_char <= fill_char_i;
                        fill_cnt  <= '0;
                        busy_o    <= 1'b1;
                    end
                end
                FILL: begin
                    if (slot_ok) begin
                        wr_en_o  <= 1'b1;
                        w_addr_o <= fill_cnt;
                        w_data_o <= {CHARS_PER_WORD{fill_char}};
                        w_strb_o <= '1;
                        if (fill_cnt == LAST_ADDR) begin
                            state       <= DONE;
                            busy_o      <= 1'b0;
                            fill_done_o <= 1'b1;
                        end else begin
                            fill_cnt <= fill_cnt + BUF_ADDR_WIDTH'(1);
                        end
                    end
                end
                DONE: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase

            // Out-of-range requests are consumed but only flagged, never written.
            if (sel_valid) begin
                if (sel_addr < ADDR_LIMIT) begin
                    wr_en_o  <= 1'b1;
                    w_addr_o <= sel_addr;
                    w_data_o <= sel_data;
                    w_strb_o <= sel_strb;
                end else begin
                    addr_err_o <= 1'b1;
                end
            end
        end
    end

endmodule
